qrs_rr_meter: RTL and testbench

Streaming ECG beat analyser that takes filtered, unsigned samples and finds each R-peak with a slope/threshold state machine. For every beat it measures the QRS width and the R-R interval, and keeps an exponential running average of R-R. It is the parametrised successor of the fixed 8-bit QRS/R-R block. Width, thresholds, refractory period and averaging depth are all configurable, and every result carries a valid strobe. It sits after the ECG filter chain and feeds the heart-rate/arrhythmia logic.

---
 rtl/qrs_rr_meter.sv | 179 +++++++++++++++++
 tb/tb_qrs_rr_meter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qrs_rr_meter.sv
// ECG beat analyser: slope/threshold R-peak FSM with QRS width, R-R interval
// and exponential R-R average, all advancing only on accepted samples.
module qrs_rr_meter #(
  parameter int DW       = 8,
  parameter int CW       = 16,
  parameter int SLOPE_TH = 4,
  parameter int QRS_MAX  = 50,
  parameter int REFRACT  = 50,
  parameter int AVG_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic [DW-1:0] th,
  output logic          r_peak,
  output logic          rr_valid,
  output logic [CW-1:0] rr_int,
  output logic [CW-1:0] rr_avg,
  output logic          qrs_valid,
  output logic [CW-1:0] qrs_width,
  output logic          qrs_err,
  output logic          timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_REFR = 2'd3;

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] QMAX    = CW'(QRS_MAX);
  localparam logic [CW-1:0] RMAX    = CW'(REFRACT);
  localparam logic signed [DW:0] SLOPE_P = (DW+1)'(SLOPE_TH);
  localparam logic signed [DW:0] SLOPE_N = -SLOPE_P;
  localparam logic signed [DW:0] ZERO    = '0;

  logic [1:0]        state, nstate;
  logic [DW-1:0]     prev;
  logic              first;
  logic [CW-1:0]     w, w_n, w_inc;
  logic [CW-1:0]     rc, rc_n;
  logic [CW-1:0]     rr_cnt, cnt_inc;
  logic              armed, has_avg;
  logic              peak, qv, qe_n;
  logic [CW-1:0]     qw_n;
  logic signed [DW:0] d;
  logic signed [CW:0] avg_diff, avg_step, avg_sum;
  logic [CW-1:0]     avg_next;

  assign d        = $signed({1'b0, s_data}) - $signed({1'b0, prev});
  assign w_inc    = w + ONE;
  assign cnt_inc  = (rr_cnt == CNT_MAX) ? rr_cnt : rr_cnt + ONE;
  // Arithmetic shift of the signed difference floors toward minus infinity.
  assign avg_diff = $signed({1'b0, cnt_inc}) - $signed({1'b0, rr_avg});
  assign avg_step = avg_diff >>> AVG_LOG2;
  assign avg_sum  = $signed({1'b0, rr_avg}) + avg_step;
  assign avg_next = avg_sum[CW-1:0];

  always_comb begin
    nstate = state;
    w_n    = w;
    rc_n   = rc;
    peak   = 1'b0;
    qv     = 1'b0;
    qw_n   = qrs_width;
    qe_n   = qrs_err;
    if (first) begin
      nstate = state;
    end else begin
      case (state)
        S_IDLE: begin
          if (d > SLOPE_P) begin
            w_n    = ONE;
            nstate = S_UP;
          end else begin
            nstate = S_IDLE;
          end
        end
        S_UP: begin
          w_n = w_inc;
          if (d <= ZERO) begin
            if (prev >= th) begin
              peak   = 1'b1;
              nstate = S_DOWN;
            end else begin
              nstate = S_IDLE;
            end
          end else if (w_inc >= QMAX) begin
            nstate = S_IDLE;
          end else begin
            nstate = S_UP;
          end
        end
        S_DOWN: begin
          w_n = w_inc;
          if (d >= SLOPE_N) begin
            qv     = 1'b1;
            qw_n   = w_inc;
            qe_n   = 1'b0;
            rc_n   = '0;
            nstate = S_REFR;
          end else if (w_inc >= QMAX) begin
            qv     = 1'b1;
            qw_n   = QMAX;
            qe_n   = 1'b1;
            rc_n   = '0;
            nstate = S_REFR;
          end else begin
            nstate = S_DOWN;
          end
        end
        S_REFR: begin
          rc_n = rc + ONE;
          if (rc_n >= RMAX) begin
            nstate = S_IDLE;
          end else begin
            nstate = S_REFR;
          end
        end
        default: nstate = S_IDLE;
      endcase
    end
  end

  // Pulses default low every cycle; all state moves only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      prev      <= '0;
      first     <= 1'b1;
      w         <= '0;
      rc        <= '0;
      rr_cnt    <= '0;
      armed     <= 1'b0;
      has_avg   <= 1'b0;
      r_peak    <= 1'b0;
      rr_valid  <= 1'b0;
      rr_int    <= '0;
      rr_avg    <= '0;
      qrs_valid <= 1'b0;
      qrs_width <= '0;
      qrs_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      r_peak    <= 1'b0;
      rr_valid  <= 1'b0;
      qrs_valid <= 1'b0;
      if (s_valid) begin
        prev      <= s_data;
        first     <= 1'b0;
        state     <= nstate;
        w         <= w_n;
        rc        <= rc_n;
        r_peak    <= peak;
        qrs_valid <= qv;
        qrs_width <= qw_n;
        qrs_err   <= qe_n;
        if (peak) begin
          rr_cnt  <= '0;
          timeout <= 1'b0;
          armed   <= 1'b1;
          // The first detection only arms the interval counter.
          if (armed) begin
            rr_valid <= 1'b1;
            rr_int   <= cnt_inc;
            rr_avg   <= has_avg ? avg_next : cnt_inc;
            has_avg  <= 1'b1;
          end
        end else begin
          rr_cnt  <= cnt_inc;
          timeout <= (cnt_inc == CNT_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_qrs_rr_meter.sv
// Scoreboard bench for qrs_rr_meter: an index-based beat model predicts every
// accepted sample's outputs; a negedge monitor pops and compares.
module tb_qrs_rr_meter;
  localparam int DW = 8, CW = 8, SL = 4, QM = 20, RF = 10, AL = 3;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [DW-1:0] th = 8'd100;
  logic r_peak, rr_valid, qrs_valid, qrs_err, timeout;
  logic [CW-1:0] rr_int, rr_avg, qrs_width;

  qrs_rr_meter #(.DW(DW), .CW(CW), .SLOPE_TH(SL), .QRS_MAX(QM), .REFRACT(RF), .AVG_LOG2(AL)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .th(th),
    .r_peak(r_peak), .rr_valid(rr_valid), .rr_int(rr_int), .rr_avg(rr_avg),
    .qrs_valid(qrs_valid), .qrs_width(qrs_width), .qrs_err(qrs_err), .timeout(timeout));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; bit rp; bit rv; bit qv; bit qe; bit to; int rr; int avg; int qw;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  bit mon_en = 1'b0;
  bit gap_mode = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Behavioural model: beat phases tracked by sample indices of onset/offset/detection.
  localparam int P_IDLE = 0, P_RISE = 1, P_FALL = 2, P_QUIET = 3;
  int m_idx, m_prev, m_phase, m_onset, m_offset, m_last, m_rr, m_avg, m_qw;
  bit m_armed, m_has_avg, m_qe;

  task automatic model_reset();
    m_idx = 0; m_prev = 0; m_phase = P_IDLE; m_onset = 0; m_offset = 0; m_last = -1;
    m_rr = 0; m_avg = 0; m_qw = 0; m_armed = 0; m_has_avg = 0; m_qe = 0;
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if (a < 0 && (a % b) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_step(input int x, input int thv, output exp_t e);
    int d, width, gap;
    e = '{default: 0};
    if (m_idx > 0) begin
      d = x - m_prev;
      width = m_idx - m_onset + 1;
      case (m_phase)
        P_IDLE: if (d > SL) begin m_phase = P_RISE; m_onset = m_idx; end
        P_RISE: begin
          if (d <= 0) begin
            if (m_prev >= thv) begin e.rp = 1; m_phase = P_FALL; end
            else m_phase = P_IDLE;
          end else if (width >= QM) m_phase = P_IDLE;
        end
        P_FALL: begin
          if (d >= -SL) begin
            e.qv = 1; m_qw = width; m_qe = 0; m_phase = P_QUIET; m_offset = m_idx;
          end else if (width >= QM) begin
            e.qv = 1; m_qw = QM; m_qe = 1; m_phase = P_QUIET; m_offset = m_idx;
          end
        end
        default: if (m_idx - m_offset >= RF) m_phase = P_IDLE;
      endcase
    end
    if (e.rp) begin
      gap = m_idx - m_last;
      if (gap > MAXC) gap = MAXC;
      if (m_armed) begin
        e.rv = 1;
        m_rr = gap;
        m_avg = m_has_avg ? m_avg + floor_div(gap - m_avg, 1 << AL) : gap;
        m_has_avg = 1;
      end
      m_armed = 1;
      m_last = m_idx;
    end
    e.to = (m_idx - m_last) >= MAXC;
    e.rr = m_rr; e.avg = m_avg; e.qw = m_qw; e.qe = m_qe;
    m_prev = x;
    m_idx++;
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    s_data = DW'($urandom_range(0, 255));
    @(posedge clk); #1;
  endtask

  task automatic send(input int x);
    exp_t e;
    s_valid = 1'b1;
    s_data = DW'(x);
    model_step(x, int'(th), e);
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    if (gap_mode) idle_cycle();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) send(20);
  endtask

  task automatic beat1();
    int b[10] = '{20, 20, 20, 40, 80, 120, 90, 50, 20, 20};
    for (int i = 0; i < 10; i++) send(b[i]);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; s_valid = 1'b0;
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_r_peak", r_peak, 0);    chk("rst_rr_valid", rr_valid, 0);
    chk("rst_qrs_valid", qrs_valid, 0); chk("rst_rr_int", rr_int, 0);
    chk("rst_rr_avg", rr_avg, 0);    chk("rst_qrs_width", qrs_width, 0);
    chk("rst_qrs_err", qrs_err, 0);  chk("rst_timeout", timeout, 0);
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Monitor: pop the record due this cycle, otherwise no pulse may appear.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("stale_entry", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("r_peak", r_peak, e.rp);
        chk("rr_valid", rr_valid, e.rv);
        chk("qrs_valid", qrs_valid, e.qv);
        chk("timeout", timeout, e.to);
        chk("rr_int", rr_int, e.rr);
        chk("rr_avg", rr_avg, e.avg);
        chk("qrs_width", qrs_width, e.qw);
        chk("qrs_err", qrs_err, e.qe);
      end else begin
        chk("idle_r_peak", r_peak, 0);
        chk("idle_rr_valid", rr_valid, 0);
        chk("idle_qrs_valid", qrs_valid, 0);
      end
    end
  end

  initial begin
    int amp, v, n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();

    // first beat: width 7, no rr_valid
    th = 8'd100;
    beat1();
    chk("beat1_qrs_width", qrs_width, 7);
    chk("beat1_qrs_err", qrs_err, 0);

    // detections 100 then 80 apart
    fill(90); beat1();
    chk("rr100_int", rr_int, 100);
    chk("rr100_avg", rr_avg, 100);
    fill(70); beat1();
    chk("rr80_int", rr_int, 80);
    chk("rr80_avg", rr_avg, 97);
    fill(15);

    // sub-threshold bump
    send(40); send(70); send(90); send(60); send(30); send(20); fill(5);

    // forced termination at QRS_MAX, then ignored upstroke inside refractory
    send(20); send(100); send(200);
    for (int k = 1; k <= 18; k++) send(200 - 5 * k);
    chk("long_qrs_width", qrs_width, 20);
    chk("long_qrs_err", qrs_err, 1);
    send(150); send(250); send(150); send(110);
    fill(15);

    // alternating s_valid
    gap_mode = 1'b1;
    beat1(); fill(30); beat1();
    gap_mode = 1'b0;
    chk("gap_qrs_width", qrs_width, 7);
    fill(15);

    // timeout saturation
    fill(300);
    chk("timeout_set", timeout, 1);
    beat1();
    chk("timeout_rr_int", rr_int, 255);
    chk("timeout_clear", timeout, 0);
    fill(15);

    // reset mid-DOWN; next beat is the first beat again
    send(20); send(40); send(80); send(120); send(90); send(50);
    do_reset();
    beat1(); fill(40); beat1(); fill(15);

    // randomized beats, thresholds, noise and stalls
    for (int b = 0; b < 40; b++) begin
      th = DW'($urandom_range(80, 160));
      gap_mode = ($urandom_range(0, 3) == 0);
      n = $urandom_range(8, 40);
      for (int i = 0; i < n; i++) send(20 + $urandom_range(0, 2));
      amp = $urandom_range(60, 250);
      v = 20;
      while (v < amp) begin v = clamp(v + $urandom_range(5, 60)); send(v); end
      while (v > 25) begin v = clamp(v - $urandom_range(3, 40)); send(v); end
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    gap_mode = 1'b0;
    fill(5);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
